freq_divider_prog: RTL and testbench
====================================

# freq_divider_prog

Runtime-programmable clock-enable/divided-clock generator, the parametrised successor of the fixed-ratio divider. Divides `clk` by a divisor loaded at run time, with independently programmable high time (duty cycle). Also produces a one-cycle period-start strobe. New settings are accepted through a valid/ready handshake and applied only at a period boundary, so the output never glitches or produces a truncated period. Sits beside the clock/reset infrastructure and drives baud, PWM and sampling timers as a clock enable.

## Interface

Parameters:
- `WIDTH`, 8: width of divisor, high-time and counter.
- `DEFAULT_DIV`, 2: divisor after reset; must be 1..2^WIDTH-1.
- `DEFAULT_HIGH`, DEFAULT_DIV/2: high time after reset; must be ≤ DEFAULT_DIV.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  run enable.
- `cfg_valid`  in  1  new configuration offered.
- `cfg_ready`  out  1  configuration slot free.
- `div_in`  in  WIDTH  requested divisor (period in `clk` cycles).
- `high_in`  in  WIDTH  requested high cycles per period.
- `cfg_err`  out  1  one-cycle pulse: offered config rejected.
- `divided_clk`  out  1  divided clock, registered.
- `tick`  out  1  one-cycle pulse at each period start, registered.

## Operation

- State:
  - `cnt` (WIDTH): period counter.
  - Active `div_a` and `high_a`.
  - Pending `div_p` and `high_p`, with `pend` flag.
- Reset (async, `rst`=0):
  - `cnt`=0; `div_a`=DEFAULT_DIV; `high_a`=DEFAULT_HIGH; `pend`=0.
  - Outputs: `cfg_ready`=1, `cfg_err`=0, `divided_clk`=0, `tick`=0.
- Handshake:
  - A transfer occurs when `cfg_valid`&&`cfg_ready`.
  - `cfg_ready` = !`pend`, registered. At most one config is ever pending; no queueing.
- Validation on transfer:
  - `div_in`=0: rejected. `cfg_err` pulses the next cycle; `pend` stays 0; active settings unchanged.
  - Otherwise, `div_p`=`div_in` and `high_p`=min(`high_in`, `div_in`) (saturating clamp); `pend`=1.
- Running (`en`=1):
  - Next `cnt` = (`cnt`==`div_a`-1) ? 0 : `cnt`+1.
  - Boundary = (`cnt`==`div_a`-1). At a boundary with `pend`=1: `div_a`←`div_p`, `high_a`←`high_p`, `pend`←0.
  - `divided_clk` ← (`cnt` < `high_a`).
  - `tick` ← (`cnt`==0).
- Idle (`en`=0):
  - `cnt`←0; `divided_clk`←0; `tick`←0.
  - A pending config is applied on the next edge (boundary is implicit while idle).
- Degenerate settings:
  - `high_a`=0: `divided_clk` constant 0.
  - `high_a`=`div_a`: constant 1.
  - `div_a`=1: `tick` is asserted every cycle; `divided_clk`=1 if `high_a`=1.
- Comparisons are unsigned, WIDTH bits. `cnt` never exceeds `div_a`-1.

## Timing

- Outputs lag `cnt` by one cycle: the edge that loads `cnt`=k registers outputs for `cnt`=k-1's value.
- First period after `en` rises:
  - `cnt`=0 in the first enabled cycle.
  - `tick`=1 and `divided_clk`=(0<`high_a`) one cycle later.
- Period = `div_a` cycles exactly. The high phase spans `high_a` consecutive cycles starting with the `tick` cycle.
- Config latency:
  - Transfer in cycle N → `pend` and `cfg_ready`=0 visible at N+1.
  - The config is applied at the first boundary edge at or after N+1, so earliest application is N+1 when idle or at a boundary.
  - `cfg_ready` returns to 1 the cycle after application.
- The period in progress always completes with the old settings. The first `tick` with new settings marks the first new period.
- `cfg_err` is asserted exactly one cycle after the rejected transfer. `cfg_ready` stays 1 through a rejection.
- Reset mid-period: outputs drop asynchronously; the pending config is discarded; DEFAULT_* values are restored.
- `en` falling mid-period: the period is abandoned; `divided_clk`=0 and `tick`=0 from the next edge.

## Test plan

- **Defaults:** after reset release, `en`=1 with DEFAULT_DIV=2, DEFAULT_HIGH=1 → `divided_clk` alternates 1,0; `tick` every 2nd cycle, coincident with high.
- **Reprogram mid-period:** running div=2; during the first cycle of a period, offer div=5, high=2 → the current period finishes; afterwards `divided_clk` is 1,1,0,0,0 repeating; `cfg_ready` is low from transfer until one cycle after application; no short pulse.
- **Clamp and degenerate cases:**
  - div=4, high=9 → `divided_clk` constant 1.
  - div=1, high=0 → `tick` every cycle, `divided_clk` 0.
  - div=3, high=0 → constant 0.
- **Rejection:** offer div=0, high=3 → `cfg_err`=1 for one cycle; `cfg_ready` stays 1; output period unchanged.
- **Back-pressure:** hold `cfg_valid`=1 with two successive configs (div=6, then div=3) → the second is accepted only after the first applies; periods are 6 then 3, none skipped.
- **Reset/enable interruptions:**
  - Assert `rst`=0 asynchronously mid-high-phase → `divided_clk` falls without a clock edge; defaults resume on release.
  - `en` low for 3 cycles with a config pending → the config is applied while idle; `tick` occurs 1 cycle after `en` re-rises.

Source files
------------

// File: rtl/freq_divider_prog.sv
// freq_divider_prog: programmable clock divider / clock-enable generator.
// A new divisor and high time are taken through a valid/ready handshake,
// held as a single pending slot, and applied only at a period boundary
// (or while idle), so the output period is never truncated.
module freq_divider_prog #(
  parameter int WIDTH        = 8,
  parameter int DEFAULT_DIV  = 2,
  parameter int DEFAULT_HIGH = DEFAULT_DIV / 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] div_in,
  input  logic [WIDTH-1:0] high_in,
  output logic             cfg_err,
  output logic             divided_clk,
  output logic             tick
);

  localparam logic [WIDTH-1:0] DIV_RST  = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] HIGH_RST = WIDTH'(DEFAULT_HIGH);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] div_a;
  logic [WIDTH-1:0] high_a;
  logic [WIDTH-1:0] div_p;
  logic [WIDTH-1:0] high_p;
  logic             pend;

  logic             boundary;
  logic [WIDTH-1:0] cnt_nxt;
  logic             xfer;
  logic             apply;
  logic [WIDTH-1:0] high_clamp;

  // Only one configuration can be outstanding; the slot is free when nothing is pending.
  assign cfg_ready = !pend;

  // Period boundary detection, next count, handshake and clamp of the requested high time.
  always_comb begin
    boundary   = (cnt == (div_a - WIDTH'(1)));
    cnt_nxt    = boundary ? '0 : cnt + WIDTH'(1);
    xfer       = cfg_valid && !pend;
    // While idle every edge is treated as a boundary, so a pending config lands at once.
    apply      = pend && (boundary || !en);
    high_clamp = (high_in > div_in) ? div_in : high_in;
  end

  // Counter, active/pending configuration and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      div_a       <= DIV_RST;
      high_a      <= HIGH_RST;
      div_p       <= DIV_RST;
      high_p      <= HIGH_RST;
      pend        <= 1'b0;
      cfg_err     <= 1'b0;
      divided_clk <= 1'b0;
      tick        <= 1'b0;
    end else begin
      cfg_err <= 1'b0;

      if (xfer) begin
        if (div_in == '0) begin
          cfg_err <= 1'b1;
        end else begin
          div_p  <= div_in;
          high_p <= high_clamp;
          pend   <= 1'b1;
        end
      end

      // Outputs reflect the count value present before this edge, using the
      // settings of the period that count belongs to.
      if (en) begin
        cnt         <= cnt_nxt;
        divided_clk <= (cnt < high_a);
        tick        <= (cnt == '0);
      end else begin
        cnt         <= '0;
        divided_clk <= 1'b0;
        tick        <= 1'b0;
      end

      // xfer requires !pend and apply requires pend, so the two never collide on pend.
      if (apply) begin
        div_a  <= div_p;
        high_a <= high_p;
        pend   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_freq_divider_prog.sv
// Directed, table-driven bench for freq_divider_prog with default parameters
// (WIDTH=8, DEFAULT_DIV=2, DEFAULT_HIGH=1).
module tb_freq_divider_prog;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] div_in;
  logic [7:0] high_in;
  logic       cfg_err;
  logic       divided_clk;
  logic       tick;

  int total = 0;
  int bad   = 0;

  freq_divider_prog #(.WIDTH(8), .DEFAULT_DIV(2), .DEFAULT_HIGH(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .div_in      (div_in),
    .high_in     (high_in),
    .cfg_err     (cfg_err),
    .divided_clk (divided_clk),
    .tick        (tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       valid;
    logic [7:0] div;
    logic [7:0] high;
    logic       dc;
    logic       tk;
    logic       rdy;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic e, input logic v, input logic [7:0] d, input logic [7:0] h,
                     input logic xdc, input logic xtk, input logic xrdy, input logic xerr);
    vec_t r;
    r.en = e; r.valid = v; r.div = d; r.high = h;
    r.dc = xdc; r.tk = xtk; r.rdy = xrdy; r.err = xerr;
    vecs.push_back(r);
  endtask

  task automatic chk(input string nm, input int idx, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s[%0d]: got %b want %b at %0t", nm, idx, got, want, $time);
    end
  endtask

  task automatic chk_outs(input string nm, input int idx,
                          input logic xdc, input logic xtk, input logic xrdy, input logic xerr);
    chk({nm, ".divided_clk"}, idx, divided_clk, xdc);
    chk({nm, ".tick"},        idx, tick,        xtk);
    chk({nm, ".cfg_ready"},   idx, cfg_ready,   xrdy);
    chk({nm, ".cfg_err"},     idx, cfg_err,     xerr);
  endtask

  // Drive inputs, take one rising edge, then compare just after it.
  task automatic step_chk(input string nm, input int idx,
                          input logic e, input logic v, input logic [7:0] d, input logic [7:0] h,
                          input logic xdc, input logic xtk, input logic xrdy, input logic xerr);
    en = e; cfg_valid = v; div_in = d; high_in = h;
    @(posedge clk);
    #1;
    chk_outs(nm, idx, xdc, xtk, xrdy, xerr);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; cfg_valid = 1'b0; div_in = '0; high_in = '0;

    // defaults: div=2 high=1
    add(1,0,0,0, 1,1,1,0); add(1,0,0,0, 0,0,1,0); add(1,0,0,0, 1,1,1,0); add(1,0,0,0, 0,0,1,0);
    // reprogram at period start: div=5 high=2
    add(1,1,5,2, 1,1,0,0); add(1,0,0,0, 0,0,1,0);
    add(1,0,0,0, 1,1,1,0); add(1,0,0,0, 1,0,1,0); add(1,0,0,0, 0,0,1,0); add(1,0,0,0, 0,0,1,0);
    add(1,0,0,0, 0,0,1,0);
    add(1,0,0,0, 1,1,1,0); add(1,0,0,0, 1,0,1,0); add(1,0,0,0, 0,0,1,0); add(1,0,0,0, 0,0,1,0);
    add(1,0,0,0, 0,0,1,0);
    // clamp: div=4 high=9 -> constant high
    add(1,1,4,9, 1,1,0,0); add(1,0,0,0, 1,0,0,0); add(1,0,0,0, 0,0,0,0); add(1,0,0,0, 0,0,0,0);
    add(1,0,0,0, 0,0,1,0);
    add(1,0,0,0, 1,1,1,0); add(1,0,0,0, 1,0,1,0); add(1,0,0,0, 1,0,1,0); add(1,0,0,0, 1,0,1,0);
    // div=1 high=0 -> tick every cycle, clock low
    add(1,1,1,0, 1,1,0,0); add(1,0,0,0, 1,0,0,0); add(1,0,0,0, 1,0,0,0); add(1,0,0,0, 1,0,1,0);
    add(1,0,0,0, 0,1,1,0); add(1,0,0,0, 0,1,1,0);
    // div=3 high=0 -> constant low, tick every third cycle
    add(1,1,3,0, 0,1,0,0); add(1,0,0,0, 0,1,1,0);
    add(1,0,0,0, 0,1,1,0); add(1,0,0,0, 0,0,1,0); add(1,0,0,0, 0,0,1,0); add(1,0,0,0, 0,1,1,0);
    // rejection: div=0 high=3
    add(1,1,0,3, 0,0,1,1); add(1,0,0,0, 0,0,1,0); add(1,0,0,0, 0,1,1,0);
    add(1,0,0,0, 0,0,1,0); add(1,0,0,0, 0,0,1,0); add(1,0,0,0, 0,1,1,0);
    // back-pressure: valid held, div=6 high=3 then div=3 high=1
    add(1,1,6,3, 0,0,0,0); add(1,1,3,1, 0,0,1,0); add(1,1,3,1, 1,1,0,0);
    add(1,0,0,0, 1,0,0,0); add(1,0,0,0, 1,0,0,0); add(1,0,0,0, 0,0,0,0); add(1,0,0,0, 0,0,0,0);
    add(1,0,0,0, 0,0,1,0);
    add(1,0,0,0, 1,1,1,0); add(1,0,0,0, 0,0,1,0); add(1,0,0,0, 0,0,1,0);
    // leave div=5 high=5 pending, clock high, for the reset sequence
    add(1,1,5,5, 1,1,0,0);

    // reset state
    #3;
    chk_outs("reset", 0, 0, 0, 1, 0);
    #9 rst = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i])
      step_chk("vec", i, vecs[i].en, vecs[i].valid, vecs[i].div, vecs[i].high,
               vecs[i].dc, vecs[i].tk, vecs[i].rdy, vecs[i].err);

    // asynchronous reset in the high phase with a config pending
    cfg_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk_outs("async_rst", 0, 0, 0, 1, 0);
    #3 rst = 1'b1;
    step_chk("rst_resume", 0, 1,0,0,0, 1,1,1,0);
    step_chk("rst_resume", 1, 1,0,0,0, 0,0,1,0);
    step_chk("rst_resume", 2, 1,0,0,0, 1,1,1,0);
    step_chk("rst_resume", 3, 1,0,0,0, 0,0,1,0);

    // en low for three cycles with div=4 high=1 pending
    step_chk("idle_apply", 0, 1,1,4,1, 1,1,0,0);
    step_chk("idle_apply", 1, 0,0,0,0, 0,0,1,0);
    step_chk("idle_apply", 2, 0,0,0,0, 0,0,1,0);
    step_chk("idle_apply", 3, 0,0,0,0, 0,0,1,0);
    step_chk("idle_apply", 4, 1,0,0,0, 1,1,1,0);
    step_chk("idle_apply", 5, 1,0,0,0, 0,0,1,0);
    step_chk("idle_apply", 6, 1,0,0,0, 0,0,1,0);
    step_chk("idle_apply", 7, 1,0,0,0, 0,0,1,0);
    step_chk("idle_apply", 8, 1,0,0,0, 1,1,1,0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
